// File: rtl/line_rotation_pkg.sv
// ----------------------------------------------------------------------------
// line_rotation_pkg
//  Shared definitions for the line_rotator / line_derotator pair.
//  - LINE_SIZE / ACTIVE_START / ACTIVE_LEN / CUT_STEP default geometry
//  - state_e : derotator line FSM {WAIT_LINE, FILL, RUN}
//  - cut_to_offset() : raw DRBG cut -> rotation offset in samples, the same
//    mapping the rotator applies, so both ends agree on every line.
// ----------------------------------------------------------------------------
package line_rotation_pkg;

    localparam int LINE_SIZE    = 1716;
    localparam int ACTIVE_START = 276;
    localparam int ACTIVE_LEN   = 1440;
    localparam int CUT_STEP     = 4;

    typedef enum logic [1:0] {
        WAIT_LINE = 2'd0,
        FILL      = 2'd1,
        RUN       = 2'd2
    } state_e;

    // raw*step can reach at most 2*len-1 for legal geometries, so a single
    // conditional subtract is a full modulo.
    function automatic logic [15:0] cut_to_offset(input logic [7:0]  raw,
                                                   input int unsigned step,
                                                   input int unsigned len);
        int unsigned prod;
        prod = 32'(raw) * step;
        if (prod >= len) prod = prod - len;
        return prod[15:0];
    endfunction

endpackage

// File: rtl/line_buffer_dp.sv
// ----------------------------------------------------------------------------
// line_buffer_dp
//  Simple dual-port RAM, one write port and one read port, registered read
//  (data for raddr_i appears on rdata_o the cycle after it is presented).
//  No reset on the array or the read register so it maps onto block RAM.
// Ports
//  clk_i    in   clock
//  we_i     in   write enable
//  waddr_i  in   write address
//  wdata_i  in   write data
//  raddr_i  in   read address
//  rdata_o  out  read data, one cycle after raddr_i
// ----------------------------------------------------------------------------
module line_buffer_dp #(
    parameter int DEPTH = 3432,
    parameter int DW    = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_derotator.sv
// ----------------------------------------------------------------------------
// line_derotator
//  Undoes the per-line rotation applied by line_rotator. One full line is
//  written into a ping-pong buffer while the previous line is read back with
//  the inverse rotation over the active region; blanking/EAV/SAV words are
//  read at their own address, so they pass through with the same delay.
//  Output = input of the previous line, LINE_SIZE + 2 cycles later.
//
//  Optional feature: define LINE_DEROTATOR_CUT_CHECK_EN to add the
//  cut_error_count port (active lines that started without a valid cut).
//
// Ports
//  clk               in   sample clock
//  reset_n           in   asynchronous active-low reset
//  data_in[9:0]      in   scrambled BT.656 sample
//  H                 in   horizontal flag, rising edge = line start
//  V                 in   vertical blanking flag (such lines are never rotated)
//  raw_cut_position  in   raw cut from the DRBG consumer
//  cut_valid         in   raw_cut_position valid this cycle
//  data_out[9:0]     out  restored sample (registered)
//  data_valid        out  data_out holds a restored line sample
//  cut_error_count   out  [LINE_DEROTATOR_CUT_CHECK_EN] saturating error count
// ----------------------------------------------------------------------------
module line_derotator #(
    parameter int LINE_SIZE    = line_rotation_pkg::LINE_SIZE,
    parameter int ACTIVE_START = line_rotation_pkg::ACTIVE_START,
    parameter int ACTIVE_LEN   = line_rotation_pkg::ACTIVE_LEN,
    parameter int CUT_STEP     = line_rotation_pkg::CUT_STEP
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  data_in,
    input  logic        H,
    input  logic        V,
    input  logic [7:0]  raw_cut_position,
    input  logic        cut_valid,
    output logic [9:0]  data_out,
    output logic        data_valid
`ifdef LINE_DEROTATOR_CUT_CHECK_EN
    ,
    output logic [15:0] cut_error_count
`endif
);

    import line_rotation_pkg::*;

    localparam int AW = $clog2(2 * LINE_SIZE);

    localparam logic [15:0] LS      = 16'(LINE_SIZE);
    localparam logic [15:0] LS_M1   = 16'(LINE_SIZE - 1);
    localparam logic [15:0] ACT_BEG = 16'(ACTIVE_START);
    localparam logic [15:0] ACT_END = 16'(ACTIVE_START + ACTIVE_LEN);
    localparam logic [15:0] ACT_LEN = 16'(ACTIVE_LEN);

    // ---------------------------------------------------------------- state
    logic        h_q;
    logic [15:0] k_q, k_d;
    logic        bank_q, bank_d;
    logic [15:0] wr_off_q, wr_off_d;    // cut of the line being written
    logic [15:0] rd_off_q, rd_off_d;    // cut of the line being read back
    state_e      state_q, state_d;
    logic [1:0]  vld_pipe;              // [0] RAM read stage, [1] output reg
    logic [9:0]  data_out_q;

    // ------------------------------------------------------------ datapath
    logic          line_start;
    logic          we;
    logic          rd_vld;
    logic [15:0]   new_off;
    logic [15:0]   rel_i, rel_j, rd_k;
    logic [15:0]   waddr_w, raddr_w;
    logic [AW-1:0] waddr, raddr;
    logic [9:0]    rdata;

    always_comb begin
        line_start = H & ~h_q;

        // Sample index of the current cycle; saturates on an over-long line.
        if (line_start)          k_d = '0;
        else if (k_q == LS_M1)   k_d = k_q;
        else                     k_d = k_q + 16'd1;

        // Samples past the end of an over-long line are dropped.
        we = line_start | (k_q != LS_M1);

        bank_d = line_start ? ~bank_q : bank_q;

        new_off = '0;
        if (cut_valid && !V)
            new_off = cut_to_offset(raw_cut_position, CUT_STEP, ACTIVE_LEN);

        // At a line start the line just finished becomes the read line, so
        // its cut moves from the write latch to the read latch.
        wr_off_d = line_start ? new_off  : wr_off_q;
        rd_off_d = line_start ? wr_off_q : rd_off_q;

        // Inverse rotation: the rotator emitted S[i] = A[(i+off) mod LEN],
        // so A[i] sits at stored position (i - off) mod LEN.
        rel_i = '0;
        rel_j = '0;
        rd_k  = k_d;
        if (k_d >= ACT_BEG && k_d < ACT_END) begin
            rel_i = k_d - ACT_BEG;
            rel_j = rel_i + ACT_LEN - rd_off_d;
            if (rel_j >= ACT_LEN) rel_j = rel_j - ACT_LEN;
            rd_k = ACT_BEG + rel_j;
        end

        waddr_w = bank_d ? (LS + k_d)  : k_d;
        raddr_w = bank_d ? rd_k        : (LS + rd_k);
        waddr   = waddr_w[AW-1:0];
        raddr   = raddr_w[AW-1:0];
    end

    // ------------------------------------------------------------ FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LINE: if (line_start) state_d = FILL;
            FILL:      if (line_start) state_d = RUN;
            RUN:       state_d = RUN;
            default:   state_d = WAIT_LINE;
        endcase
        // Reads are meaningful from the H rise that enters RUN onwards.
        rd_vld = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q        <= 1'b0;
            k_q        <= '0;
            bank_q     <= 1'b0;
            wr_off_q   <= '0;
            rd_off_q   <= '0;
            state_q    <= WAIT_LINE;
            vld_pipe   <= '0;
            data_out_q <= '0;
        end else begin
            h_q        <= H;
            k_q        <= k_d;
            bank_q     <= bank_d;
            wr_off_q   <= wr_off_d;
            rd_off_q   <= rd_off_d;
            state_q    <= state_d;
            vld_pipe   <= {vld_pipe[0], rd_vld};
            data_out_q <= rdata;
        end
    end

    line_buffer_dp #(
        .DEPTH (2 * LINE_SIZE),
        .DW    (10),
        .AW    (AW)
    ) u_buf (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (data_in),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign data_out   = data_out_q;
    assign data_valid = vld_pipe[1];

`ifdef LINE_DEROTATOR_CUT_CHECK_EN
    logic [15:0] cut_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cut_err_q <= '0;
        else if (line_start && !V && !cut_valid && cut_err_q != 16'hFFFF)
            cut_err_q <= cut_err_q + 16'd1;
    end

    assign cut_error_count = cut_err_q;
`endif

endmodule

// File: tb/tb_line_derotator.sv
module tb_line_derotator;
    import line_rotation_pkg::*;

    localparam int LS = LINE_SIZE;
    localparam int AS = ACTIVE_START;
    localparam int AL = ACTIVE_LEN;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] data_in = '0;
    logic       H = 1'b0;
    logic       V = 1'b0;
    logic [7:0] raw_cut_position = '0;
    logic       cut_valid = 1'b0;
    logic [9:0] data_out;
    logic       data_valid;
`ifdef LINE_DEROTATOR_CUT_CHECK_EN
    logic [15:0] cut_error_count;
`endif

    always #5 clk = ~clk;

    line_derotator dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .data_in          (data_in),
        .H                (H),
        .V                (V),
        .raw_cut_position (raw_cut_position),
        .cut_valid        (cut_valid),
        .data_out         (data_out),
        .data_valid       (data_valid)
`ifdef LINE_DEROTATOR_CUT_CHECK_EN
        ,
        .cut_error_count  (cut_error_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [9:0] cur_exp  [LS];
    logic [9:0] prev_exp [LS];

    // Expectation for the read issued in the previous cycle; its result is
    // visible just after the following clock edge.
    logic [9:0] e_dat = '0;
    logic       e_vld = 1'b0;
    logic       e_chk = 1'b0;

    // Original (unscrambled) content of line l at sample k.
    function automatic logic [9:0] pat(input int l, input int k);
        return 10'((k * 7 + l * 113) & 1023);
    endfunction

    task automatic idle(input int n);
        int vmis;
        vmis = 0;
        for (int c = 0; c < n; c++) begin
            data_in = '0; H = 1'b0; V = 1'b0; cut_valid = 1'b0; raw_cut_position = 8'h00;
            @(posedge clk); @(negedge clk);
            if (data_valid !== e_vld) vmis++;
            e_vld = 1'b0; e_chk = 1'b0;
        end
        total++;
        assert (vmis === 0) else begin
            bad++;
            $error("FAIL idle_valid mismatches=%0d want=0", vmis);
        end
    endtask

    // Drive one line (rotated by the cut when one applies) and check the
    // read-back of the previous line that happens during it.
    task automatic run_line(input int l, input logic v, input logic cv, input logic [7:0] raw,
                            input int len, input logic rd_vld, input logic rd_chk);
        int off, dmis, vmis, nchk, dk, vk;
        logic [9:0] dgot, dwant;
        logic vgot, vwant;
        off = (cv && !v) ? int'(raw) * CUT_STEP : 0;
        if (off >= AL) off -= AL;
        dmis = 0; vmis = 0; nchk = 0; dk = -1; vk = -1;
        dgot = '0; dwant = '0; vgot = 1'b0; vwant = 1'b0;
        for (int k = 0; k < len; k++) begin
            cur_exp[k] = pat(l, k);
            if (k >= AS && k < AS + AL) data_in = pat(l, AS + (k - AS + off) % AL);
            else                        data_in = pat(l, k);
            H = (k < 268);
            V = v;
            cut_valid = (k == 0) ? cv : 1'b0;
            raw_cut_position = (k == 0) ? raw : 8'h5A;
            @(posedge clk); @(negedge clk);
            if (data_valid !== e_vld) begin
                if (vmis == 0) begin vk = k; vgot = data_valid; vwant = e_vld; end
                vmis++;
            end
            if (e_chk) begin
                nchk++;
                if (data_out !== e_dat) begin
                    if (dmis == 0) begin dk = k; dgot = data_out; dwant = e_dat; end
                    dmis++;
                end
            end
            e_dat = prev_exp[k]; e_vld = rd_vld; e_chk = rd_chk;
        end
        total++;
        assert (vmis === 0) else begin
            bad++;
            $error("FAIL line%0d_valid mismatches=%0d first k=%0d got=%0b want=%0b", l, vmis, vk, vgot, vwant);
        end
        if (nchk > 0) begin
            total++;
            assert (dmis === 0) else begin
                bad++;
                $error("FAIL line%0d_data mismatches=%0d first k=%0d got=%h want=%h", l, dmis, dk, dgot, dwant);
            end
        end
        for (int k = 0; k < LS; k++) prev_exp[k] = cur_exp[k];
    endtask

    initial begin
        for (int k = 0; k < LS; k++) begin cur_exp[k] = '0; prev_exp[k] = '0; end

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; assert (data_out === 10'h000) else begin bad++; $error("FAIL rst_data got=%h want=000", data_out); end
        total++; assert (data_valid === 1'b0) else begin bad++; $error("FAIL rst_valid got=%0b want=0", data_valid); end
`ifdef LINE_DEROTATOR_CUT_CHECK_EN
        total++; assert (cut_error_count === 16'h0) else begin bad++; $error("FAIL rst_cnt got=%0d want=0", cut_error_count); end
`endif
        reset_n = 1'b1;
        idle(4);

        // Ramp lines, cut 0: line 0 is the fill line, valid from line 1 on
        run_line(0, 1'b0, 1'b1, 8'd0,   LS, 1'b0, 1'b0);
        run_line(1, 1'b0, 1'b1, 8'd0,   LS, 1'b1, 1'b1);
        run_line(2, 1'b0, 1'b1, 8'd0,   LS, 1'b1, 1'b1);
        // Rotations of 40, 1020 and 800 samples
        run_line(3, 1'b0, 1'b1, 8'd10,  LS, 1'b1, 1'b1);
        run_line(4, 1'b0, 1'b1, 8'd255, LS, 1'b1, 1'b1);
        run_line(5, 1'b0, 1'b1, 8'd200, LS, 1'b1, 1'b1);
        // Vertical blanking line with a valid cut: never rotated
        run_line(6, 1'b1, 1'b1, 8'd50,  LS, 1'b1, 1'b1);
        // Reset at k=700 of the next line
        run_line(7, 1'b0, 1'b1, 8'd0,   700, 1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        total++; assert (data_valid === 1'b0) else begin bad++; $error("FAIL midrst_valid got=%0b want=0", data_valid); end
        total++; assert (data_out === 10'h000) else begin bad++; $error("FAIL midrst_data got=%h want=000", data_out); end
        e_vld = 1'b0; e_chk = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(4);

        // Fill line again, then lines without a cut (two active, one V=1)
        run_line(8,  1'b0, 1'b1, 8'd10, LS, 1'b0, 1'b0);
        run_line(9,  1'b0, 1'b0, 8'd77, LS, 1'b1, 1'b1);
        run_line(10, 1'b0, 1'b0, 8'd0,  LS, 1'b1, 1'b1);
        run_line(11, 1'b1, 1'b0, 8'd0,  LS, 1'b1, 1'b1);
        run_line(12, 1'b0, 1'b1, 8'd0,  LS, 1'b1, 1'b1);
`ifdef LINE_DEROTATOR_CUT_CHECK_EN
        total++; assert (cut_error_count === 16'd2) else begin bad++; $error("FAIL cut_err got=%0d want=2", cut_error_count); end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
